// File: rtl/bpred_pkg.sv
// Shared constants and counter helpers for the pattern history table predictor.
package bpred_pkg;

    localparam int BPRED_BIMODAL = 0;
    localparam int BPRED_GSHARE  = 1;

    // Weakly-not-taken: the value just below the taken threshold (0 for 1-bit counters).
    function automatic int ctr_reset_val(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // One saturating step toward the resolved direction; never wraps at either end.
    function automatic int sat_step(input int ctr, input logic taken, input int ctr_bits);
        int ctr_max;
        ctr_max = (1 << ctr_bits) - 1;
        if (taken) begin
            return (ctr < ctr_max) ? ctr + 1 : ctr;
        end
        return (ctr > 0) ? ctr - 1 : ctr;
    endfunction

endpackage

// File: rtl/bpred_pht_if.sv
// Predict/update bus between fetch, branch resolve and the pattern history table.
interface bpred_pht_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int STAT_BITS  = 16
);

    logic                  pred_valid;
    logic [PC_WIDTH-1:0]   pred_pc;
    logic                  pred_out_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_ghr;

    logic                  upd_valid;
    logic [PC_WIDTH-1:0]   upd_pc;
    logic [INDEX_BITS-1:0] upd_ghr;
    logic                  upd_taken;
    logic                  upd_mispredict;

    logic [INDEX_BITS-1:0] ghr;
    logic [STAT_BITS-1:0]  mispredict_count;

    // Pipeline side: issues lookups and resolved outcomes.
    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_out_valid, pred_taken, pred_ghr, ghr, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_out_valid, pred_taken, pred_ghr, ghr, mispredict_count
    );

endinterface

// File: rtl/bpred_sat_ctr.sv
// Single PHT entry: saturating up/down counter with synchronous reset.
module bpred_sat_ctr
    import bpred_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_d;

    // Step toward the resolved direction only when this entry is addressed.
    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            ctr_d = CTR_BITS'(sat_step(32'(ctr_q), taken_i, CTR_BITS));
        end
    end

    // Counter register; reset wins over any concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= CTR_RST;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/bpred_pht.sv
// Pattern history table branch predictor (bimodal or gshare indexing) with a
// registered lookup port, an independent update port and mispredict statistics.
module bpred_pht
    import bpred_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = BPRED_BIMODAL,
    parameter int STAT_BITS  = 16
) (
    input logic        clk,
    input logic        rst,
    bpred_pht_if.slave bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    logic [CTR_BITS-1:0]   ctr_w [ENTRIES];
    logic [CTR_BITS-1:0]   pred_ctr;

    logic [INDEX_BITS-1:0] pc_pidx;
    logic [INDEX_BITS-1:0] pc_uidx;
    logic [INDEX_BITS-1:0] pidx;
    logic [INDEX_BITS-1:0] uidx;

    logic [INDEX_BITS-1:0] ghr_q;
    logic [INDEX_BITS-1:0] ghr_d;
    logic [INDEX_BITS-1:0] ghr_shift;

    logic                  pred_out_valid_q;
    logic                  pred_out_valid_d;
    logic                  pred_taken_q;
    logic                  pred_taken_d;
    logic [INDEX_BITS-1:0] pred_ghr_q;
    logic [INDEX_BITS-1:0] pred_ghr_d;

    logic [STAT_BITS-1:0]  mis_cnt_q;
    logic [STAT_BITS-1:0]  mis_cnt_d;

    // Only the index bits of the PCs matter; upd_ghr is dead in bimodal mode.
    logic unused_ok;
    assign unused_ok = ^{bus.pred_pc, bus.upd_pc, bus.upd_ghr, pred_ctr};

    assign pc_pidx = bus.pred_pc[INDEX_BITS+1:2];
    assign pc_uidx = bus.upd_pc[INDEX_BITS+1:2];
    assign pidx    = (MODE == BPRED_GSHARE) ? (pc_pidx ^ ghr_q)       : pc_pidx;
    assign uidx    = (MODE == BPRED_GSHARE) ? (pc_uidx ^ bus.upd_ghr) : pc_uidx;

    // Table is flops so that a single reset cycle restores every entry.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bpred_sat_ctr #(
            .CTR_BITS(CTR_BITS)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .en_i    (bus.upd_valid && (uidx == INDEX_BITS'(i))),
            .taken_i (bus.upd_taken),
            .ctr_o   (ctr_w[i])
        );
    end

    // Read-before-write: a same-cycle update is not forwarded into the lookup.
    assign pred_ctr = ctr_w[pidx];

    if (INDEX_BITS == 1) begin : g_ghr_one
        assign ghr_shift = bus.upd_taken;
    end else begin : g_ghr_multi
        assign ghr_shift = {ghr_q[INDEX_BITS-2:0], bus.upd_taken};
    end

    // Next-state for lookup result, history and statistics.
    always_comb begin
        pred_out_valid_d = bus.pred_valid;
        pred_taken_d     = pred_taken_q;
        pred_ghr_d       = pred_ghr_q;
        if (bus.pred_valid) begin
            pred_taken_d = pred_ctr[CTR_BITS-1];
            pred_ghr_d   = ghr_q;
        end

        ghr_d = bus.upd_valid ? ghr_shift : ghr_q;

        mis_cnt_d = mis_cnt_q;
        if (bus.upd_valid && bus.upd_mispredict && (mis_cnt_q != STAT_MAX)) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
        end
    end

    // State registers; reset drops in-flight lookups and clears history/statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_ghr_q       <= '0;
            ghr_q            <= '0;
            mis_cnt_q        <= '0;
        end else begin
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_ghr_q       <= pred_ghr_d;
            ghr_q            <= ghr_d;
            mis_cnt_q        <= mis_cnt_d;
        end
    end

    assign bus.pred_out_valid   = pred_out_valid_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.pred_ghr         = pred_ghr_q;
    assign bus.ghr              = ghr_q;
    assign bus.mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_bpred_pht.sv
// Directed bench for bpred_pht: a bimodal instance (6 index bits, 2-bit stats)
// and a gshare instance (4 index bits).
module tb_bpred_pht;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bpred_pht_if #(.PC_WIDTH(32), .INDEX_BITS(6), .STAT_BITS(2))  if0 ();
    bpred_pht_if #(.PC_WIDTH(32), .INDEX_BITS(4), .STAT_BITS(16)) if1 ();

    bpred_pht #(
        .PC_WIDTH(32), .INDEX_BITS(6), .CTR_BITS(2), .MODE(0), .STAT_BITS(2)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    bpred_pht #(
        .PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .MODE(1), .STAT_BITS(16)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.pred_valid = 0; if0.pred_pc = '0; if0.upd_valid = 0; if0.upd_pc = '0;
        if0.upd_ghr = '0; if0.upd_taken = 0; if0.upd_mispredict = 0;
        if1.pred_valid = 0; if1.pred_pc = '0; if1.upd_valid = 0; if1.upd_pc = '0;
        if1.upd_ghr = '0; if1.upd_taken = 0; if1.upd_mispredict = 0;
    endtask

    task automatic pred0(input logic [31:0] pc);
        if0.pred_valid = 1; if0.pred_pc = pc;
        step();
        if0.pred_valid = 0;
    endtask

    task automatic upd0(input logic [31:0] pc, input logic taken, input logic mis);
        if0.upd_valid = 1; if0.upd_pc = pc; if0.upd_taken = taken; if0.upd_mispredict = mis;
        step();
        if0.upd_valid = 0; if0.upd_mispredict = 0;
    endtask

    task automatic pred1(input logic [31:0] pc);
        if1.pred_valid = 1; if1.pred_pc = pc;
        step();
        if1.pred_valid = 0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic [3:0] g, input logic taken);
        if1.upd_valid = 1; if1.upd_pc = pc; if1.upd_ghr = g; if1.upd_taken = taken;
        step();
        if1.upd_valid = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        step();
        step();
        rst = 0;
        checks++; if (if0.pred_out_valid !== 1'b0) begin errors++; $display("FAIL rst_pov: got %0b want 0", if0.pred_out_valid); end
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %0b want 0", if0.pred_taken); end
        checks++; if (if0.pred_ghr !== 6'h00) begin errors++; $display("FAIL rst_pred_ghr: got %h want 00", if0.pred_ghr); end
        checks++; if (if0.ghr !== 6'h00) begin errors++; $display("FAIL rst_ghr: got %h want 00", if0.ghr); end
        checks++; if (if0.mispredict_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", if0.mispredict_count); end
        checks++; if (if1.ghr !== 4'h0) begin errors++; $display("FAIL rst_ghr1: got %h want 0", if1.ghr); end
        pred0(32'h40);
        checks++; if (if0.pred_out_valid !== 1'b1) begin errors++; $display("FAIL first_pov: got %0b want 1", if0.pred_out_valid); end
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL first_taken: got %0b want 0", if0.pred_taken); end
        checks++; if (if0.pred_ghr !== 6'h00) begin errors++; $display("FAIL first_pred_ghr: got %h want 00", if0.pred_ghr); end
        step();
        checks++; if (if0.pred_out_valid !== 1'b0) begin errors++; $display("FAIL idle_pov: got %0b want 0", if0.pred_out_valid); end
    endtask

    task automatic test_bimodal();
        // entry 16 starts at 1
        upd0(32'h40, 1, 0);                          // -> 2
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b1) begin errors++; $display("FAIL bim_after_one_taken: got %0b want 1", if0.pred_taken); end
        for (int i = 0; i < 3; i++) upd0(32'h40, 1, 0);   // saturates at 3
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b1) begin errors++; $display("FAIL bim_sat_hi: got %0b want 1", if0.pred_taken); end
        upd0(32'h40, 0, 0);                          // -> 2
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b1) begin errors++; $display("FAIL bim_first_nt: got %0b want 1", if0.pred_taken); end
        upd0(32'h40, 0, 0);                          // -> 1
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL bim_second_nt: got %0b want 0", if0.pred_taken); end
        upd0(32'h40, 0, 0);                          // -> 0
        upd0(32'h40, 0, 0);                          // holds 0
        upd0(32'h40, 1, 0);                          // -> 1
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL bim_sat_lo: got %0b want 0", if0.pred_taken); end
        // history T T T T N N N N T -> last six 100001
        checks++; if (if0.ghr !== 6'h21) begin errors++; $display("FAIL bim_ghr: got %h want 21", if0.ghr); end
        checks++; if (if0.mispredict_count !== 2'd0) begin errors++; $display("FAIL bim_count: got %0d want 0", if0.mispredict_count); end
    endtask

    task automatic test_back_to_back();
        // entry 32 at 1; lookup and taken update in the same cycle
        if0.pred_valid = 1; if0.pred_pc = 32'h80;
        if0.upd_valid = 1;  if0.upd_pc = 32'h80; if0.upd_taken = 1;
        step();
        if0.pred_valid = 0; if0.upd_valid = 0;
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_taken: got %0b want 0", if0.pred_taken); end
        checks++; if (if0.pred_ghr !== 6'h21) begin errors++; $display("FAIL same_cycle_ghr: got %h want 21", if0.pred_ghr); end
        pred0(32'h80);
        checks++; if (if0.pred_taken !== 1'b1) begin errors++; $display("FAIL after_same_taken: got %0b want 1", if0.pred_taken); end
        checks++; if (if0.pred_ghr !== 6'h03) begin errors++; $display("FAIL after_same_ghr: got %h want 03", if0.pred_ghr); end
    endtask

    task automatic test_gshare();
        upd1(32'h3C, 4'h0, 1);
        upd1(32'h3C, 4'h0, 0);
        upd1(32'h3C, 4'h0, 1);
        checks++; if (if1.ghr !== 4'b0101) begin errors++; $display("FAIL gs_ghr: got %b want 0101", if1.ghr); end
        pred1(32'h14);                               // 5 ^ 5 -> entry 0
        checks++; if (if1.pred_taken !== 1'b0) begin errors++; $display("FAIL gs_pred_e0: got %0b want 0", if1.pred_taken); end
        checks++; if (if1.pred_ghr !== 4'b0101) begin errors++; $display("FAIL gs_pred_ghr: got %b want 0101", if1.pred_ghr); end
        upd1(32'h14, 4'b0101, 1);                    // entry 0 -> 2, ghr -> 1011
        checks++; if (if1.ghr !== 4'b1011) begin errors++; $display("FAIL gs_ghr2: got %b want 1011", if1.ghr); end
        pred1(32'h2C);                               // 11 ^ 11 -> entry 0
        checks++; if (if1.pred_taken !== 1'b1) begin errors++; $display("FAIL gs_entry0_mod: got %0b want 1", if1.pred_taken); end
        checks++; if (if1.pred_ghr !== 4'b1011) begin errors++; $display("FAIL gs_pred_ghr2: got %b want 1011", if1.pred_ghr); end
        pred1(32'h38);                               // 14 ^ 11 -> entry 5
        checks++; if (if1.pred_taken !== 1'b0) begin errors++; $display("FAIL gs_entry5_same: got %0b want 0", if1.pred_taken); end
    endtask

    task automatic test_stats();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        if0.upd_valid = 0; if0.upd_mispredict = 1;
        step();
        if0.upd_mispredict = 0;
        checks++; if (if0.mispredict_count !== 2'd0) begin errors++; $display("FAIL stat_no_valid: got %0d want 0", if0.mispredict_count); end
        for (int i = 0; i < 5; i++) begin
            upd0(32'hC0, 1, 1);                      // entry 48 ends at 3
            checks++;
            if (if0.mispredict_count !== exp_cnt[i]) begin
                errors++; $display("FAIL stat_seq[%0d]: got %0d want %0d", i, if0.mispredict_count, exp_cnt[i]);
            end
        end
        if0.upd_valid = 0; if0.upd_mispredict = 1;
        step();
        if0.upd_mispredict = 0;
        checks++; if (if0.mispredict_count !== 2'd3) begin errors++; $display("FAIL stat_hold: got %0d want 3", if0.mispredict_count); end
    endtask

    task automatic test_reset_mid();
        pred0(32'h80);                               // leaves pred_taken=1
        if0.pred_valid = 1; if0.pred_pc = 32'h40;
        if0.upd_valid = 1; if0.upd_pc = 32'hC0; if0.upd_taken = 1; if0.upd_mispredict = 1;
        if1.pred_valid = 1; if1.pred_pc = 32'h2C;
        if1.upd_valid = 1; if1.upd_pc = 32'h2C; if1.upd_ghr = 4'b1011; if1.upd_taken = 1;
        rst = 1;
        step();
        rst = 0;
        idle_all();
        checks++; if (if0.pred_out_valid !== 1'b0) begin errors++; $display("FAIL mid_pov: got %0b want 0", if0.pred_out_valid); end
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL mid_taken: got %0b want 0", if0.pred_taken); end
        checks++; if (if0.ghr !== 6'h00) begin errors++; $display("FAIL mid_ghr: got %h want 00", if0.ghr); end
        checks++; if (if0.mispredict_count !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", if0.mispredict_count); end
        checks++; if (if1.pred_out_valid !== 1'b0) begin errors++; $display("FAIL mid_pov1: got %0b want 0", if1.pred_out_valid); end
        checks++; if (if1.ghr !== 4'h0) begin errors++; $display("FAIL mid_ghr1: got %h want 0", if1.ghr); end
        upd0(32'hC0, 0, 0);                          // reset 1 -> 0 (unreset 3 -> 2)
        pred0(32'hC0);
        checks++; if (if0.pred_taken !== 1'b0) begin errors++; $display("FAIL mid_e48: got %0b want 0", if0.pred_taken); end
        upd0(32'h40, 1, 0);                          // reset 1 -> 2
        pred0(32'h40);
        checks++; if (if0.pred_taken !== 1'b1) begin errors++; $display("FAIL mid_e16: got %0b want 1", if0.pred_taken); end
        checks++; if (if0.pred_ghr !== 6'h01) begin errors++; $display("FAIL mid_pred_ghr: got %h want 01", if0.pred_ghr); end
    endtask

    initial begin
        rst = 1;
        idle_all();
        test_reset();
        test_bimodal();
        test_back_to_back();
        test_gshare();
        test_stats();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpred_pht.md
Name: bpred_pht

Overview:
- Parametrised successor to the single-bit last-outcome predictor in the core library.
- Pattern history table (PHT) of saturating counters, indexed by branch PC, optionally XORed with a global history register (gshare mode).
- Registered prediction port and independent update port. Sits between fetch (predict) and execute/branch-resolve (update).
- Saturating mispredict statistics counter for performance monitoring.

Parameters:
- PC_WIDTH, 32, width of pc inputs.
- INDEX_BITS, 6, log2 of PHT entries (64); index taken from pc[INDEX_BITS+1:2].
- CTR_BITS, 2, saturating counter width (>=1); predict taken when counter MSB = 1.
- MODE, 0, 0 = bimodal (PC index only), 1 = gshare (PC index XOR GHR).
- STAT_BITS, 16, width of mispredict statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pred_valid  in  1  lookup request this cycle
- pred_pc  in  PC_WIDTH  PC of branch being fetched
- pred_out_valid  out  1  prediction result valid (pred_valid delayed 1 cycle)
- pred_taken  out  1  predicted direction
- pred_ghr  out  INDEX_BITS  GHR value used for this lookup; fetch carries it down the pipe
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  PC_WIDTH  PC of resolved branch
- upd_ghr  in  INDEX_BITS  GHR captured at prediction time (pred_ghr echoed back)
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  pipeline flagged this branch mispredicted
- ghr  out  INDEX_BITS  current speculative-free global history
- mispredict_count  out  STAT_BITS  saturating count of upd_valid & upd_mispredict

Behaviour:
- Reset (rst=1 at clk edge):
  - All PHT counters set to weakly-not-taken, 2^(CTR_BITS-1)-1. For CTR_BITS=1 this is 0.
  - ghr = 0, pred_out_valid = 0, pred_taken = 0, pred_ghr = 0, mispredict_count = 0.
  - Reset dominates any concurrent pred_valid/upd_valid.
- Index:
  - pidx = pred_pc[INDEX_BITS+1:2] ^ (MODE ? ghr : 0).
  - uidx = upd_pc[INDEX_BITS+1:2] ^ (MODE ? upd_ghr : 0).
- Prediction, latency 1:
  - On a cycle with pred_valid=1, the next cycle shows pred_out_valid=1, pred_taken = PHT[pidx][CTR_BITS-1], and pred_ghr = ghr as sampled.
  - With pred_valid=0, pred_out_valid=0 the next cycle; pred_taken and pred_ghr hold their last values.
- Update:
  - On upd_valid=1, PHT[uidx] increments if upd_taken=1, otherwise decrements.
  - The counter saturates at 2^CTR_BITS-1 and at 0; it never wraps.
- GHR:
  - On upd_valid=1, ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - If INDEX_BITS=1, ghr <= upd_taken.
  - ghr is maintained in both modes but only used for indexing when MODE=1.
- Simultaneous predict and update in the same cycle:
  - Same index: the prediction uses the pre-update counter value (read-before-write, no forwarding).
  - pidx always uses the pre-shift ghr.
- Statistics:
  - mispredict_count increments on upd_valid & upd_mispredict.
  - It saturates at all-ones and holds there; it clears only on rst.
  - upd_mispredict is ignored when upd_valid=0.
- Reset mid-operation: in-flight predictions are dropped (pred_out_valid=0 the cycle after rst). No update issued in a reset cycle takes effect.
- Storage: flops, not RAM, so that one-cycle full-table reset is possible. Depth is bounded in practice to INDEX_BITS <= 10.

Decomposition:
- Package bpred_pkg:
  - mode constants BPRED_BIMODAL=0, BPRED_GSHARE=1;
  - function ctr_reset_val(CTR_BITS);
  - function sat_step(ctr, taken), which saturates.
- Sub-module bpred_sat_ctr, parameter CTR_BITS: one counter with synchronous reset, an enable, and a taken input; outputs the counter value. bpred_pht instantiates 2^INDEX_BITS of them in a generate loop.

Test Plan:
- Reset then pred_valid, pred_pc=0x40 -> next cycle pred_out_valid=1, pred_taken=0, pred_ghr=0; all other outputs 0.
- MODE=0, CTR_BITS=2: upd_pc=0x40 taken x1 -> next predict of 0x40 gives 1.
  - 3 further taken updates -> counter holds at 3.
  - 2 not-taken updates -> prediction 0 after the second.
  - 2 more not-taken updates -> counter holds at 0.
- Same-cycle pred_pc=upd_pc=0x80 with the counter at 1 and upd_taken=1 -> that prediction is 0, and the following lookup is 1.
- MODE=1, INDEX_BITS=4:
  - updates taken, not-taken, taken -> ghr=4'b0101.
  - pred_pc=0x14 (pc idx 5) -> reads entry 0, and pred_ghr=0101.
  - update with upd_ghr=0101, upd_pc=0x14, taken -> entry 0 modified, entry 5 unchanged.
- STAT_BITS=2: 5 updates with upd_mispredict=1 -> mispredict_count sequence 1, 2, 3, 3, 3. upd_mispredict=1 with upd_valid=0 -> no change.
- Assert rst for one cycle while pred_valid=1 and upd_valid=1 -> next cycle pred_out_valid=0, ghr=0, count=0, all counters back at 1.
